// File: rtl/byte_serial_complement.sv
// Byte-serial 32-bit ones'/two's complement unit. A single 8-bit inverter/incrementer
// slice walks the operand LSB-first, with the carry held in a register between bytes.
module byte_serial_complement #(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [8*N_BYTES-1:0]   a,
    output logic                   ready,
    output logic                   done,
    output logic [8*N_BYTES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int W  = 8 * N_BYTES;
    localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(N_BYTES - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic          r_mode;
    logic [KW-1:0] r_k;
    logic          r_c;
    logic [W-1:0]  r_stage;

    logic [KW+2:0] w_base;
    logic [7:0]    w_byte;
    logic [8:0]    w_sum;
    logic [W-1:0]  w_stage_next;

    // One slice of the complement: invert the byte and add the incoming carry.
    function automatic logic [8:0] f_byte_cmp(input logic [7:0] b, input logic cin);
        return {1'b0, ~b} + {8'd0, cin};
    endfunction

    function automatic logic f_is_most_neg(input logic [W-1:0] v);
        return (v == MOST_NEG);
    endfunction

    assign w_base = {r_k, 3'b000};
    assign w_byte = r_a[w_base +: 8];
    assign w_sum  = f_byte_cmp(w_byte, r_c);

    // Staging with the current byte merged in, so the last RUN cycle can publish it directly.
    always_comb begin
        w_stage_next = r_stage;
        w_stage_next[w_base +: 8] = w_sum[7:0];
    end

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_mode    <= 1'b0;
            r_k       <= '0;
            r_c       <= 1'b0;
            r_stage   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_mode  <= mode;
                        r_k     <= '0;
                        r_c     <= mode;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_stage <= w_stage_next;
                    r_c     <= w_sum[8];
                    if (r_k == K_LAST) begin
                        r_k       <= '0;
                        r_state   <= S_DONE;
                        result    <= w_stage_next;
                        carry_out <= r_mode & w_sum[8];
                        overflow  <= r_mode & f_is_most_neg(r_a);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_complement.sv
// Scoreboard bench for byte_serial_complement: expected results are queued when a start
// is accepted and compared against the DUT when done pulses.
module tb_byte_serial_complement;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    int cyc;
    int chk_cnt;
    int err_cnt;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    byte_serial_complement #(.N_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [31:0] av, input int c);
        exp_t e;
        logic [32:0] s;
        s = {1'b0, ~av} + {32'd0, m};
        e.res = s[31:0];
        e.co  = m & s[32];
        e.ov  = m && (av == 32'h8000_0000);
        e.cyc = c + 5;
        return e;
    endfunction

    // Monitor: accept detection pushes, done pops and compares.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("carry_out", carry_out, e.co);
                    chk("overflow", overflow, e.ov);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (ready && start) sb.push_back(model(mode, a, cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (!ready && n < max) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic op(input logic m, input logic [31:0] av);
        wait_ready(20);
        start = 1'b1;
        mode  = m;
        a     = av;
        tick();
        start = 1'b0;
        wait_empty(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        a       = '0;
        repeat (2) tick();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        op(1'b1, 32'h0000_0100);
        op(1'b1, 32'h0000_0000);
        op(1'b1, 32'h8000_0000);
        op(1'b0, 32'h1234_5678);
        op(1'b0, 32'hFFFF_FFFF);
        op(1'b1, 32'h7FFF_FFFF);
        op(1'b0, 32'h0000_0000);

        // start pulses while busy must be ignored; the start in cycle 6 is accepted
        wait_ready(20);
        start = 1'b1; mode = 1'b1; a = 32'h0000_0001;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 32'h5555_5555;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        chk("busy_done_c5", done, 1);
        chk("busy_ready_c5", ready, 0);
        tick();
        chk("busy_ready_c6", ready, 1);
        tick();
        start = 1'b0;
        wait_empty(20);

        // asynchronous reset mid-RUN aborts the operation
        wait_ready(20);
        start = 1'b1; mode = 1'b1; a = 32'h0000_00FF;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_carry", carry_out, 0);
        chk("abort_ovf", overflow, 0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            chk("post_abort_done", done, 0);
        end
        chk("post_abort_ready", ready, 1);
        chk("post_abort_result", result, 0);
        op(1'b1, 32'h0000_00FF);

        // start held high: accepted every 6 cycles
        wait_ready(20);
        start = 1'b1; mode = 1'b1; a = 32'h0000_1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ready_%0d", i), ready, (i % 6) == 0);
            chk($sformatf("hold_done_%0d", i), done, (i % 6) == 5);
            tick();
        end
        start = 1'b0;
        wait_empty(20);

        // a few random operands
        for (int i = 0; i < 6; i++) begin
            op(1'($urandom_range(0, 1)), $urandom);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/byte_serial_complement.md
# byte_serial_complement

Multi-cycle 32-bit complement unit that produces either the ones' complement (~a) or the two's complement (~a + 1) of an operand. It processes one byte per cycle through a single 8-bit inverter/incrementer slice, with the carry rippling between bytes in a register. It serves ALU negate/subtract-prep and NOR-style operations where area matters more than latency. A start/ready/done handshake connects it to the multi-cycle ALU controller.

## Interface
- N_BYTES, 4, number of byte slices processed; operand width is 8*N_BYTES (32 at default).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- mode  in  1  0 = ones' complement, 1 = two's complement; sampled with start.
- a  in  8*N_BYTES  operand; sampled with start.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; result/carry_out/overflow valid in that cycle and held afterwards.
- result  out  8*N_BYTES  complement result.
- carry_out  out  1  final carry out of the top byte (mode=1 only, else 0).
- overflow  out  1  mode=1 and a = 0x80000000 (most negative value).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 at a clock edge:
  - latch a and mode;
  - set byte index k=0;
  - set carry register c=mode;
  - go to RUN.
- RUN: ready=0. Each cycle processes byte k:
  - s = {1'b0, ~a_lat[8k+7:8k]} + c (9-bit sum);
  - staging byte k <= s[7:0];
  - c <= s[8];
  - k <= k+1.
  - After byte N_BYTES-1, go to DONE.
- Transition RUN->DONE writes the output registers:
  - result <= staging, including the final byte computed that cycle;
  - carry_out <= final c if mode=1, else 0;
  - overflow <= (mode=1 && a_lat == {1'b1, {8*N_BYTES-1{1'b0}}}).
- DONE: done=1, ready=0 for exactly one cycle, then go to IDLE.
- start while ready=0 is ignored and not queued; the in-flight operation is unaffected.
- result, carry_out and overflow hold their values until the next RUN->DONE transition. They never show partial (byte-wise) results.
- Arithmetic: modulo 2^(8*N_BYTES). No saturation; the overflow flag only reports the condition.
- mode=0: the carry register is forced to 0 at start, so the result is purely bitwise ~a.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, done=0, result=0, carry_out=0, overflow=0, k=0, c=0.
- Reset asserted mid-RUN or in DONE aborts the operation. Nothing is written to result and no done pulse occurs.
- Latency, with start sampled at the edge ending cycle 0:
  - cycles 1..N_BYTES are RUN;
  - cycle N_BYTES+1 is DONE (done=1, outputs valid);
  - cycle N_BYTES+2 is IDLE (ready=1).
- At default N_BYTES=4: done in cycle 5; the next start can be accepted in cycle 6.
- Throughput: one operation per N_BYTES+2 cycles.
- A start held high continuously is accepted each time ready=1. Back-to-back operations are therefore spaced N_BYTES+2 cycles apart.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- mode=1, a=0x00000100 -> done in cycle 5; result=0xFFFFFF00 (carry ripples through byte 0 into byte 1); carry_out=0; overflow=0.
- mode=1, a=0x00000000 -> result=0x00000000, carry_out=1, overflow=0. Then mode=1, a=0x80000000 -> result=0x80000000, overflow=1, carry_out=0.
- mode=0, a=0x12345678 -> result=0xEDCBA987, carry_out=0. Then mode=0, a=0xFFFFFFFF -> result=0x00000000, carry_out=0.
- Issue mode=1, a=0x00000001; pulse start with a=0x55555555 in cycles 2 and 5 -> both pulses ignored; result=0xFFFFFFFF in cycle 5; ready=1 in cycle 6; a start in cycle 6 is accepted.
- Start mode=1, a=0x000000FF; assert rst_n=0 in cycle 3 -> outputs go to reset values immediately; no done pulse; after release ready=1 and result=0. A new op with a=0x000000FF then yields 0xFFFFFF01.
- Hold start=1 for 20 cycles with a fixed operand -> done pulses in cycles 5, 11 and 17; ready is high only in cycles 0, 6, 12 and 18.
